// File: rtl/cmt_queue_pkg.sv
// Shared constants and helpers for the commit queue.
//   TRAP_OPCODE  : opcode field that marks the simulation trap instruction
//   BUS_64 / REG_BUS_W : legacy bus widths kept for the surrounding code
//   entry_width(): packed width of one queued record for a given XLEN
//   is_trap()    : trap opcode detector
package cmt_queue_pkg;

    localparam logic [6:0] TRAP_OPCODE = 7'h6b;
    localparam int         BUS_64      = 64;
    localparam int         REG_BUS_W   = 64;

    // Record layout (MSB..LSB): pc, inst, wen, wdest, wdata, skip, a0
    function automatic int entry_width(input int xlen);
        return 2 * xlen + 32 + 5 + 1 + 1 + 8;
    endfunction

    function automatic logic is_trap(input logic [31:0] inst);
        return (inst[6:0] == TRAP_OPCODE);
    endfunction

endpackage

// File: rtl/cmt_fifo.sv
// Storage for the commit queue: one push port, multi-pop port.
//   clk, rst        : clock, async active-low reset
//   i_push          : write i_push_data at the write pointer (caller guarantees space)
//   i_pop_cnt       : number of entries to retire this cycle (0..CMT_WIDTH, <= o_count)
//   o_rd_data       : oldest CMT_WIDTH entries, slot g at [g*EW +: EW], combinational
//   o_count         : current occupancy
module cmt_fifo
    import cmt_queue_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int CMT_WIDTH = 2,
    parameter int EW        = 175,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = $clog2(DEPTH + 1),
    localparam int PW       = $clog2(CMT_WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic [EW-1:0]           i_push_data,
    input  logic [PW-1:0]           i_pop_cnt,
    output logic [CMT_WIDTH*EW-1:0] o_rd_data,
    output logic [CW-1:0]           o_count
);

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Entry storage; cleared on reset so no stale record can ever be presented
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= r_rd_ptr + AW'(i_pop_cnt);
            r_count  <= r_count + CW'(i_push) - CW'(i_pop_cnt);
        end
    end

    for (genvar g = 0; g < CMT_WIDTH; g++) begin : g_rd
        logic [AW-1:0] w_idx;
        assign w_idx = r_rd_ptr + AW'(g);
        assign o_rd_data[g*EW +: EW] = r_mem[w_idx];
    end

    assign o_count = r_count;

endmodule

// File: rtl/cmt_queue.sv
// Commit queue between writeback and the difftest commit interface.
// Buffers retired instructions and releases up to CMT_WIDTH per cycle in
// program order as registered commit records; latches the trap instruction
// and keeps cycle / instruction counters.
//   in_*     : retired instruction handshake (in_valid / in_ready) and payload
//   cmt_en   : downstream permits a commit this cycle
//   cmt_*    : registered per-slot commit records, slot 0 oldest
//   trap_*   : sticky trap status, code (a0[7:0]) and PC
//   cycle_cnt, instr_cnt, count : counters and current occupancy
module cmt_queue
    import cmt_queue_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int DEPTH     = 8,
    parameter int CMT_WIDTH = 2,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [XLEN-1:0]           in_pc,
    input  logic [31:0]               in_inst,
    input  logic                      in_wen,
    input  logic [4:0]                in_wdest,
    input  logic [XLEN-1:0]           in_wdata,
    input  logic                      in_skip,
    input  logic [7:0]                in_a0,
    input  logic                      cmt_en,
    output logic [CMT_WIDTH-1:0]      cmt_valid,
    output logic [CMT_WIDTH*XLEN-1:0] cmt_pc,
    output logic [CMT_WIDTH*32-1:0]   cmt_inst,
    output logic [CMT_WIDTH-1:0]      cmt_wen,
    output logic [CMT_WIDTH*8-1:0]    cmt_wdest,
    output logic [CMT_WIDTH*XLEN-1:0] cmt_wdata,
    output logic [CMT_WIDTH-1:0]      cmt_skip,
    output logic                      trap_valid,
    output logic [7:0]                trap_code,
    output logic [XLEN-1:0]           trap_pc,
    output logic [63:0]               cycle_cnt,
    output logic [63:0]               instr_cnt,
    output logic [CW-1:0]             count
);

    localparam int EW        = entry_width(XLEN);
    localparam int PW        = $clog2(CMT_WIDTH + 1);
    localparam int A0_LSB    = 0;
    localparam int SKIP_BIT  = 8;
    localparam int WDATA_LSB = 9;
    localparam int WDEST_LSB = 9 + XLEN;
    localparam int WEN_BIT   = 14 + XLEN;
    localparam int INST_LSB  = 15 + XLEN;
    localparam int PC_LSB    = 47 + XLEN;

    logic [EW-1:0]           w_push_data;
    logic                    w_push;
    logic [CMT_WIDTH*EW-1:0] w_rd_data;
    logic [CW-1:0]           w_count;

    logic [XLEN-1:0] w_slot_pc    [CMT_WIDTH];
    logic [31:0]     w_slot_inst  [CMT_WIDTH];
    logic            w_slot_wen   [CMT_WIDTH];
    logic [4:0]      w_slot_wdest [CMT_WIDTH];
    logic [XLEN-1:0] w_slot_wdata [CMT_WIDTH];
    logic            w_slot_skip  [CMT_WIDTH];
    logic [7:0]      w_slot_a0    [CMT_WIDTH];
    logic            w_slot_trap  [CMT_WIDTH];

    logic [CMT_WIDTH-1:0] w_take;
    logic [PW-1:0]        w_pop_cnt;
    logic                 w_live;
    logic                 w_trap_hit;
    logic [7:0]           w_trap_code;
    logic [XLEN-1:0]      w_trap_pc;

    logic [CMT_WIDTH-1:0]      r_cmt_valid;
    logic [CMT_WIDTH*XLEN-1:0] r_cmt_pc;
    logic [CMT_WIDTH*32-1:0]   r_cmt_inst;
    logic [CMT_WIDTH-1:0]      r_cmt_wen;
    logic [CMT_WIDTH*8-1:0]    r_cmt_wdest;
    logic [CMT_WIDTH*XLEN-1:0] r_cmt_wdata;
    logic [CMT_WIDTH-1:0]      r_cmt_skip;
    logic                      r_trap_valid;
    logic [7:0]                r_trap_code;
    logic [XLEN-1:0]           r_trap_pc;
    logic [63:0]               r_cycle_cnt;
    logic [63:0]               r_instr_cnt;

    // Ready depends only on registered state: a same-cycle pop never frees a full queue
    assign in_ready    = (w_count < CW'(DEPTH)) && !r_trap_valid;
    assign w_push      = in_valid && in_ready;
    assign w_push_data = {in_pc, in_inst, in_wen, in_wdest, in_wdata, in_skip, in_a0};

    cmt_fifo #(
        .DEPTH     (DEPTH),
        .CMT_WIDTH (CMT_WIDTH),
        .EW        (EW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop_cnt   (w_pop_cnt),
        .o_rd_data   (w_rd_data),
        .o_count     (w_count)
    );

    for (genvar g = 0; g < CMT_WIDTH; g++) begin : g_slot
        assign w_slot_pc[g]    = w_rd_data[g*EW + PC_LSB    +: XLEN];
        assign w_slot_inst[g]  = w_rd_data[g*EW + INST_LSB  +: 32];
        assign w_slot_wen[g]   = w_rd_data[g*EW + WEN_BIT];
        assign w_slot_wdest[g] = w_rd_data[g*EW + WDEST_LSB +: 5];
        assign w_slot_wdata[g] = w_rd_data[g*EW + WDATA_LSB +: XLEN];
        assign w_slot_skip[g]  = w_rd_data[g*EW + SKIP_BIT];
        assign w_slot_a0[g]    = w_rd_data[g*EW + A0_LSB    +: 8];
        assign w_slot_trap[g]  = is_trap(w_slot_inst[g]);
    end

    // Pop selection: take occupied slots in order, stopping right after the first trap.
    // A trap ends the scan, so it can only ever be the last slot taken.
    always_comb begin
        w_take      = '0;
        w_pop_cnt   = '0;
        w_live      = cmt_en && !r_trap_valid;
        w_trap_hit  = 1'b0;
        w_trap_code = 8'h00;
        w_trap_pc   = '0;
        for (int i = 0; i < CMT_WIDTH; i++) begin
            if (w_live && (CW'(i) < w_count)) begin
                w_take[i]   = 1'b1;
                w_pop_cnt   = w_pop_cnt + PW'(1);
                w_live      = !w_slot_trap[i];
                w_trap_hit  = w_slot_trap[i];
                w_trap_code = w_slot_a0[i];
                w_trap_pc   = w_slot_pc[i];
            end else begin
                w_live = 1'b0;
            end
        end
    end

    // Commit slot registers: valid pulses for exactly one cycle per popping edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmt_valid <= '0;
            r_cmt_pc    <= '0;
            r_cmt_inst  <= '0;
            r_cmt_wen   <= '0;
            r_cmt_wdest <= '0;
            r_cmt_wdata <= '0;
            r_cmt_skip  <= '0;
        end else begin
            r_cmt_valid <= w_take;
            for (int i = 0; i < CMT_WIDTH; i++) begin
                if (w_take[i]) begin
                    r_cmt_pc[i*XLEN +: XLEN]    <= w_slot_pc[i];
                    r_cmt_inst[i*32 +: 32]      <= w_slot_inst[i];
                    r_cmt_wen[i]                <= w_slot_wen[i];
                    r_cmt_wdest[i*8 +: 8]       <= {3'b000, w_slot_wdest[i]};
                    r_cmt_wdata[i*XLEN +: XLEN] <= w_slot_wdata[i];
                    r_cmt_skip[i]               <= w_slot_skip[i];
                end
            end
        end
    end

    // Sticky trap status and counters; cycle count freezes once the trap is latched
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_trap_valid <= 1'b0;
            r_trap_code  <= 8'h00;
            r_trap_pc    <= '0;
            r_cycle_cnt  <= 64'd0;
            r_instr_cnt  <= 64'd0;
        end else begin
            if (w_trap_hit) begin
                r_trap_valid <= 1'b1;
                r_trap_code  <= w_trap_code;
                r_trap_pc    <= w_trap_pc;
            end
            if (!r_trap_valid) begin
                r_cycle_cnt <= r_cycle_cnt + 64'd1;
            end
            r_instr_cnt <= r_instr_cnt + 64'(w_pop_cnt);
        end
    end

    assign cmt_valid  = r_cmt_valid;
    assign cmt_pc     = r_cmt_pc;
    assign cmt_inst   = r_cmt_inst;
    assign cmt_wen    = r_cmt_wen;
    assign cmt_wdest  = r_cmt_wdest;
    assign cmt_wdata  = r_cmt_wdata;
    assign cmt_skip   = r_cmt_skip;
    assign trap_valid = r_trap_valid;
    assign trap_code  = r_trap_code;
    assign trap_pc    = r_trap_pc;
    assign cycle_cnt  = r_cycle_cnt;
    assign instr_cnt  = r_instr_cnt;
    assign count      = w_count;

endmodule

// File: tb/tb_cmt_queue.sv
// Directed bench for cmt_queue: a CMT_WIDTH=2 instance (u_dut) and a
// CMT_WIDTH=1 instance (u_dut1) sharing the same input stimulus.
module tb_cmt_queue;

    localparam logic [31:0] ADDI = 32'h00000013;
    localparam logic [31:0] TRAP = 32'h0000006b;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid, in_wen, in_skip, cmt_en;
    logic [63:0] in_pc, in_wdata;
    logic [31:0] in_inst;
    logic [4:0]  in_wdest;
    logic [7:0]  in_a0;

    logic         in_ready, trap_valid;
    logic [1:0]   cmt_valid, cmt_wen, cmt_skip;
    logic [127:0] cmt_pc, cmt_wdata;
    logic [63:0]  cmt_inst, trap_pc, cycle_cnt, instr_cnt;
    logic [15:0]  cmt_wdest;
    logic [7:0]   trap_code;
    logic [3:0]   count;

    logic        in_ready_1, trap_valid_1;
    logic [0:0]  cmt_valid_1, cmt_wen_1, cmt_skip_1;
    logic [63:0] cmt_pc_1, cmt_wdata_1, trap_pc_1, cycle_cnt_1, instr_cnt_1;
    logic [31:0] cmt_inst_1;
    logic [7:0]  cmt_wdest_1, trap_code_1;
    logic [3:0]  count_1;

    int checks = 0;
    int errors = 0;

    cmt_queue #(.XLEN(64), .DEPTH(8), .CMT_WIDTH(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_wen(in_wen), .in_wdest(in_wdest),
        .in_wdata(in_wdata), .in_skip(in_skip), .in_a0(in_a0), .cmt_en(cmt_en),
        .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_inst(cmt_inst), .cmt_wen(cmt_wen),
        .cmt_wdest(cmt_wdest), .cmt_wdata(cmt_wdata), .cmt_skip(cmt_skip),
        .trap_valid(trap_valid), .trap_code(trap_code), .trap_pc(trap_pc),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .count(count)
    );

    cmt_queue #(.XLEN(64), .DEPTH(8), .CMT_WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_1),
        .in_pc(in_pc), .in_inst(in_inst), .in_wen(in_wen), .in_wdest(in_wdest),
        .in_wdata(in_wdata), .in_skip(in_skip), .in_a0(in_a0), .cmt_en(cmt_en),
        .cmt_valid(cmt_valid_1), .cmt_pc(cmt_pc_1), .cmt_inst(cmt_inst_1), .cmt_wen(cmt_wen_1),
        .cmt_wdest(cmt_wdest_1), .cmt_wdata(cmt_wdata_1), .cmt_skip(cmt_skip_1),
        .trap_valid(trap_valid_1), .trap_code(trap_code_1), .trap_pc(trap_pc_1),
        .cycle_cnt(cycle_cnt_1), .instr_cnt(instr_cnt_1), .count(count_1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_pc = 64'd0; in_inst = 32'd0; in_wen = 1'b0;
        in_wdest = 5'd0; in_wdata = 64'd0; in_skip = 1'b0; in_a0 = 8'd0;
        cmt_en = 1'b0;
    endtask

    task automatic drive(input logic [63:0] pc, input logic [31:0] inst, input logic [7:0] a0);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
        in_a0    = a0;
        in_wen   = 1'b1;
        in_wdest = pc[6:2];
        in_wdata = pc ^ 64'hA5A5_0000_5A5A_FFFF;
        in_skip  = 1'b0;
    endtask

    // Reset asserted and released on falling edges; returns 1 ns after the first rising edge
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [546:0] all_out;
        #1 rst = 1'b0;
        idle_inputs();
        #1;
        all_out = {cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_wdest, cmt_wdata, cmt_skip,
                   trap_valid, trap_code, trap_pc, cycle_cnt, instr_cnt, count};
        checks++; if (all_out !== '0) begin errors++; $display("FAIL reset_outputs_zero: or-reduce=%b required 0", |all_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++; if (cycle_cnt !== 64'd1) begin errors++; $display("FAIL reset_cycle_cnt: got %0d required 1", cycle_cnt); end
    endtask

    task automatic test_basic();
        int n_push = 0;
        int n_cmt  = 0;
        logic [63:0] exp_pc;
        do_reset();
        cmt_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (n_push < 5) drive(64'h8000_0000 + 64'(4 * n_push), ADDI, 8'h00);
            else in_valid = 1'b0;
            tick();
            if (n_push < 5) n_push++;
            if (c == 0) begin
                checks++; if (cmt_valid !== 2'b00) begin errors++; $display("FAIL basic_latency_early: got %b required 00", cmt_valid); end
            end
            if (c == 1) begin
                checks++; if (cmt_valid !== 2'b01) begin errors++; $display("FAIL basic_first_valid: got %b required 01", cmt_valid); end
            end
            checks++; if (cmt_valid === 2'b10) begin errors++; $display("FAIL basic_slot_order: got %b", cmt_valid); end
            for (int s = 0; s < 2; s++) begin
                if (cmt_valid[s]) begin
                    exp_pc = 64'h8000_0000 + 64'(4 * n_cmt);
                    checks++; if (cmt_pc[s*64 +: 64] !== exp_pc) begin errors++; $display("FAIL basic_pc: got %h required %h", cmt_pc[s*64 +: 64], exp_pc); end
                    n_cmt++;
                end
            end
        end
        checks++; if (n_cmt !== 5) begin errors++; $display("FAIL basic_commit_total: got %0d required 5", n_cmt); end
        checks++; if (instr_cnt !== 64'd5) begin errors++; $display("FAIL basic_instr_cnt: got %0d required 5", instr_cnt); end
    endtask

    task automatic test_full();
        logic [63:0] p0, p1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(64'h1000 + 64'(4 * i), ADDI, 8'h00);
            tick();
        end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d required 8", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b required 0", in_ready); end
        drive(64'h1020, ADDI, 8'h00);
        tick();
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_ninth_refused: got %0d required 8", count); end
        in_valid = 1'b0;
        cmt_en   = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            p0 = 64'h1000 + 64'(8 * j);
            p1 = p0 + 64'd4;
            checks++; if (cmt_valid !== 2'b11) begin errors++; $display("FAIL full_pop_valid: got %b required 11", cmt_valid); end
            checks++; if (cmt_pc !== {p1, p0}) begin errors++; $display("FAIL full_pop_pcs: got %h required %h", cmt_pc, {p1, p0}); end
            checks++; if (cmt_wdest[15:8] !== {3'b000, p1[6:2]}) begin errors++; $display("FAIL full_wdest: got %h required %h", cmt_wdest[15:8], {3'b000, p1[6:2]}); end
            checks++; if (cmt_wdata[63:0] !== (p0 ^ 64'hA5A5_0000_5A5A_FFFF)) begin errors++; $display("FAIL full_wdata: got %h", cmt_wdata[63:0]); end
            checks++; if (count !== 4'(6 - 2 * j)) begin errors++; $display("FAIL full_pop_count: got %0d required %0d", count, 6 - 2 * j); end
            if (j == 0) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_return: got %b required 1", in_ready); end
            end
        end
        tick();
        checks++; if (cmt_valid !== 2'b00) begin errors++; $display("FAIL full_drained: got %b required 00", cmt_valid); end
        checks++; if (instr_cnt !== 64'd8) begin errors++; $display("FAIL full_instr_cnt: got %0d required 8", instr_cnt); end
    endtask

    task automatic test_trap();
        do_reset();
        drive(64'h2000, ADDI, 8'h33); tick();
        drive(64'h2004, TRAP, 8'h00); tick();
        drive(64'h2008, ADDI, 8'h33); tick();
        in_valid = 1'b0;
        cmt_en   = 1'b1;
        tick();
        checks++; if (cmt_valid !== 2'b11) begin errors++; $display("FAIL trap_valid_slots: got %b required 11", cmt_valid); end
        checks++; if (cmt_pc !== {64'h2004, 64'h2000}) begin errors++; $display("FAIL trap_slot_pcs: got %h", cmt_pc); end
        checks++; if (cmt_inst[63:32] !== TRAP) begin errors++; $display("FAIL trap_slot1_inst: got %h required %h", cmt_inst[63:32], TRAP); end
        checks++; if (trap_valid !== 1'b1) begin errors++; $display("FAIL trap_flag: got %b required 1", trap_valid); end
        checks++; if (trap_code !== 8'h00) begin errors++; $display("FAIL trap_code: got %h required 00", trap_code); end
        checks++; if (trap_pc !== 64'h2004) begin errors++; $display("FAIL trap_pc: got %h required 2004", trap_pc); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL trap_count: got %0d required 1", count); end
        checks++; if (cycle_cnt !== 64'd5) begin errors++; $display("FAIL trap_cycle_at_trap: got %0d required 5", cycle_cnt); end
        drive(64'h200c, ADDI, 8'h33);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (cmt_valid !== 2'b00) begin errors++; $display("FAIL trap_no_more_commits: got %b required 00", cmt_valid); end
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL trap_in_ready: got %b required 0", in_ready); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL trap_count_hold: got %0d required 1", count); end
        checks++; if (cycle_cnt !== 64'd5) begin errors++; $display("FAIL trap_cycle_frozen: got %0d required 5", cycle_cnt); end
        checks++; if (instr_cnt !== 64'd2) begin errors++; $display("FAIL trap_instr_cnt: got %0d required 2", instr_cnt); end
        in_valid = 1'b0;
    endtask

    task automatic test_width1_trap();
        do_reset();
        drive(64'h3000, ADDI, 8'h11); tick();
        drive(64'h3004, TRAP, 8'h5A); tick();
        in_valid = 1'b0;
        cmt_en   = 1'b1;
        tick();
        checks++; if (cmt_valid_1 !== 1'b1 || cmt_pc_1 !== 64'h3000) begin errors++; $display("FAIL w1_first: valid %b pc %h required 1 3000", cmt_valid_1, cmt_pc_1); end
        checks++; if (trap_valid_1 !== 1'b0) begin errors++; $display("FAIL w1_no_trap_yet: got %b required 0", trap_valid_1); end
        tick();
        checks++; if (cmt_valid_1 !== 1'b1 || cmt_pc_1 !== 64'h3004) begin errors++; $display("FAIL w1_trap_slot: valid %b pc %h required 1 3004", cmt_valid_1, cmt_pc_1); end
        checks++; if (trap_valid_1 !== 1'b1) begin errors++; $display("FAIL w1_trap_flag: got %b required 1", trap_valid_1); end
        checks++; if (trap_code_1 !== 8'h5A) begin errors++; $display("FAIL w1_trap_code: got %h required 5a", trap_code_1); end
        checks++; if (trap_pc_1 !== 64'h3004) begin errors++; $display("FAIL w1_trap_pc: got %h required 3004", trap_pc_1); end
        checks++; if (instr_cnt_1 !== 64'd2) begin errors++; $display("FAIL w1_instr_cnt: got %0d required 2", instr_cnt_1); end
    endtask

    task automatic test_wrap();
        int   n_push = 0;
        int   n_cmt  = 0;
        int   max_cnt = 0;
        logic en = 1'b0;
        logic acc;
        logic [63:0] exp_pc;
        do_reset();
        for (int c = 0; c < 200 && n_cmt < 20; c++) begin
            if (n_push < 20) drive(64'h4000 + 64'(4 * n_push), ADDI, 8'(n_push));
            else in_valid = 1'b0;
            cmt_en = en;
            acc = in_valid && in_ready;
            tick();
            if (acc) n_push++;
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (!en) begin
                checks++; if (cmt_valid !== 2'b00) begin errors++; $display("FAIL wrap_idle_valid: got %b required 00", cmt_valid); end
            end
            checks++; if (cmt_valid === 2'b10) begin errors++; $display("FAIL wrap_slot_order: got %b", cmt_valid); end
            for (int s = 0; s < 2; s++) begin
                if (cmt_valid[s]) begin
                    exp_pc = 64'h4000 + 64'(4 * n_cmt);
                    checks++; if (cmt_pc[s*64 +: 64] !== exp_pc) begin errors++; $display("FAIL wrap_pc: got %h required %h", cmt_pc[s*64 +: 64], exp_pc); end
                    n_cmt++;
                end
            end
            en = !en;
        end
        checks++; if (n_cmt !== 20) begin errors++; $display("FAIL wrap_total: got %0d required 20", n_cmt); end
        checks++; if (instr_cnt !== 64'd20) begin errors++; $display("FAIL wrap_instr_cnt: got %0d required 20", instr_cnt); end
        checks++; if (max_cnt > 8) begin errors++; $display("FAIL wrap_count_bound: got %0d required <= 8", max_cnt); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL wrap_empty: got %0d required 0", count); end
        in_valid = 1'b0;
        cmt_en   = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [546:0] all_out;
        do_reset();
        drive(64'h5000, ADDI, 8'h01); tick();
        drive(64'h5004, TRAP, 8'h77); tick();
        for (int i = 0; i < 5; i++) begin
            drive(64'h5008 + 64'(4 * i), ADDI, 8'h01);
            tick();
        end
        in_valid = 1'b0;
        cmt_en   = 1'b1;
        tick();
        cmt_en = 1'b0;
        tick();
        checks++; if (count !== 4'd5 || trap_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_state: count %0d trap %b required 5 1", count, trap_valid); end
        #2 rst = 1'b0;
        #1;
        all_out = {cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_wdest, cmt_wdata, cmt_skip,
                   trap_valid, trap_code, trap_pc, cycle_cnt, instr_cnt, count};
        checks++; if (all_out !== '0) begin errors++; $display("FAIL mid_async_zero: or-reduce=%b required 0", |all_out); end
        @(negedge clk);
        rst    = 1'b1;
        cmt_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (cmt_valid !== 2'b00) begin errors++; $display("FAIL mid_no_stale: got %b required 00", cmt_valid); end
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b required 1", in_ready); end
        checks++; if (instr_cnt !== 64'd0 || count !== 4'd0) begin errors++; $display("FAIL mid_counts: instr %0d count %0d required 0 0", instr_cnt, count); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_full();
        test_trap();
        test_width1_trap();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
